// File: rtl/fe_capture_pkg.sv
// Shared definitions for the front-end capture sequencer.
// State codes are mirrored by the Python register map.
package fe_capture_pkg;

    localparam int FE_DELAY_W_DEF = 20;
    localparam int FE_LEN_W_DEF   = 18;

    typedef enum logic [2:0] {
        FE_ST_IDLE    = 3'd0,
        FE_ST_ARMED   = 3'd1,
        FE_ST_DELAY   = 3'd2,
        FE_ST_CAPTURE = 3'd3,
        FE_ST_DONE    = 3'd4
    } fe_state_e;

    typedef enum logic [1:0] {
        FE_FIFO_CMD_DATA = 2'd0,
        FE_FIFO_CMD_STAT = 2'd1,
        FE_FIFO_CMD_TIME = 2'd2
    } fe_fifo_cmd_e;

endpackage

// File: rtl/fe_capture_ctrl_if.sv
// Control/status bundle between register block, trigger logic and sequencer.
// FE_CAPTURE_CTRL_SEGMENTS_EN adds the multi-segment capture signals.
interface fe_capture_ctrl_if #(
    parameter int pDELAY_WIDTH = 20,
    parameter int pLEN_WIDTH   = 18
);
    logic                    I_arm;
    logic                    I_abort;
    logic                    I_trigger;
    logic [pDELAY_WIDTH-1:0] I_trigger_delay;
    logic [pLEN_WIDTH-1:0]   I_capture_len;
    logic                    I_data_wr;
    logic                    I_fifo_full;
    logic                    O_capture_enable;
    logic                    O_armed;
    logic                    O_done;
    logic                    O_overflow;
    logic [pLEN_WIDTH-1:0]   O_count;
    logic [2:0]              O_state;
`ifdef FE_CAPTURE_CTRL_SEGMENTS_EN
    logic [7:0]              I_segments;
    logic [7:0]              O_segment_count;
`endif

    modport master (
`ifdef FE_CAPTURE_CTRL_SEGMENTS_EN
        output I_segments,
        input  O_segment_count,
`endif
        output I_arm,
        output I_abort,
        output I_trigger,
        output I_trigger_delay,
        output I_capture_len,
        output I_data_wr,
        output I_fifo_full,
        input  O_capture_enable,
        input  O_armed,
        input  O_done,
        input  O_overflow,
        input  O_count,
        input  O_state
    );

    modport slave (
`ifdef FE_CAPTURE_CTRL_SEGMENTS_EN
        input  I_segments,
        output O_segment_count,
`endif
        input  I_arm,
        input  I_abort,
        input  I_trigger,
        input  I_trigger_delay,
        input  I_capture_len,
        input  I_data_wr,
        input  I_fifo_full,
        output O_capture_enable,
        output O_armed,
        output O_done,
        output O_overflow,
        output O_count,
        output O_state
    );

endinterface

// File: rtl/fe_ctrl_down_counter.sv
// Loadable down-counter that stops at zero; used for the trigger delay.
// zero_o is decoded from the registered count.
module fe_ctrl_down_counter #(
    parameter int pWIDTH = 20
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic [pWIDTH-1:0] load_val_i,
    input  logic              en_i,
    output logic              zero_o
);

    logic [pWIDTH-1:0] cnt_q;

    // Load wins over decrement; the count parks at zero.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - pWIDTH'(1);
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/fe_capture_ctrl.sv
// Capture sequencer: arm -> trigger -> delay -> capture N writes -> done.
// Optional multi-segment capture under FE_CAPTURE_CTRL_SEGMENTS_EN.
module fe_capture_ctrl
    import fe_capture_pkg::*;
#(
    parameter int pDELAY_WIDTH = FE_DELAY_W_DEF,
    parameter int pLEN_WIDTH   = FE_LEN_W_DEF
) (
    input  logic              fe_clk,
    input  logic              reset_i,
    fe_capture_ctrl_if.slave  bus
);

    localparam logic [pLEN_WIDTH-1:0] LEN_MAX = '1;

    fe_state_e               state_q;
    logic [pLEN_WIDTH-1:0]   len_q;
    logic [pLEN_WIDTH-1:0]   count_q;
    logic [pLEN_WIDTH-1:0]   count_inc;
    logic                    en_q;
    logic                    armed_q;
    logic                    done_q;
    logic                    ovf_q;
    logic                    hit_len;
    logic                    cap_end;
    logic                    seg_more;
    logic                    dly_load;
    logic                    dly_zero;
    logic [pDELAY_WIDTH-1:0] dly_val;

    assign count_inc = (count_q == LEN_MAX) ? count_q
                                            : count_q + pLEN_WIDTH'(1);
    assign hit_len   = bus.I_data_wr && (len_q != '0)
                       && (count_inc == len_q);
    assign cap_end   = hit_len || bus.I_fifo_full;
    assign dly_load  = (state_q == FE_ST_ARMED) && bus.I_trigger;
    assign dly_val   = bus.I_trigger_delay - pDELAY_WIDTH'(1);

    fe_ctrl_down_counter #(
        .pWIDTH (pDELAY_WIDTH)
    ) u_dly (
        .clk_i      (fe_clk),
        .rst_i      (reset_i),
        .load_i     (dly_load),
        .load_val_i (dly_val),
        .en_i       (state_q == FE_ST_DELAY),
        .zero_o     (dly_zero)
    );

`ifdef FE_CAPTURE_CTRL_SEGMENTS_EN
    logic [7:0] seg_tgt_q;
    logic [7:0] seg_cnt_q;
    logic [7:0] seg_inc;
    logic       arm_ok;

    assign seg_inc  = seg_cnt_q + 8'd1;
    assign seg_more = (seg_inc < seg_tgt_q);
    assign arm_ok   = bus.I_arm && ((state_q == FE_ST_IDLE)
                                 || (state_q == FE_ST_DONE));

    // Segment target sampled on arm; count advances on clean window ends.
    always_ff @(posedge fe_clk) begin
        if (reset_i) begin
            seg_tgt_q <= 8'd1;
            seg_cnt_q <= '0;
        end else if (!bus.I_abort) begin
            if (arm_ok) begin
                seg_cnt_q <= '0;
                seg_tgt_q <= (bus.I_segments == '0) ? 8'd1 : bus.I_segments;
            end else if ((state_q == FE_ST_CAPTURE) && hit_len
                         && !bus.I_fifo_full) begin
                seg_cnt_q <= seg_inc;
            end
        end
    end

    assign bus.O_segment_count = seg_cnt_q;
`else
    assign seg_more = 1'b0;
`endif

    // Sequencer FSM with registered status outputs; abort beats arm.
    always_ff @(posedge fe_clk) begin
        if (reset_i) begin
            state_q <= FE_ST_IDLE;
            en_q    <= 1'b0;
            armed_q <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            count_q <= '0;
            len_q   <= '0;
        end else if (bus.I_abort) begin
            state_q <= FE_ST_IDLE;
            en_q    <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            case (state_q)
                FE_ST_IDLE, FE_ST_DONE: begin
                    if (bus.I_arm) begin
                        state_q <= FE_ST_ARMED;
                        armed_q <= 1'b1;
                        done_q  <= 1'b0;
                        ovf_q   <= 1'b0;
                        count_q <= '0;
                        len_q   <= bus.I_capture_len;
                    end
                end
                FE_ST_ARMED: begin
                    if (bus.I_trigger) begin
                        armed_q <= 1'b0;
                        if (bus.I_trigger_delay == '0) begin
                            state_q <= FE_ST_CAPTURE;
                            en_q    <= 1'b1;
                        end else begin
                            state_q <= FE_ST_DELAY;
                        end
                    end
                end
                FE_ST_DELAY: begin
                    if (dly_zero) begin
                        state_q <= FE_ST_CAPTURE;
                        en_q    <= 1'b1;
                    end
                end
                FE_ST_CAPTURE: begin
                    if (bus.I_data_wr) begin
                        count_q <= count_inc;
                    end
                    if (bus.I_fifo_full) begin
                        ovf_q <= 1'b1;
                    end
                    if (cap_end) begin
                        en_q <= 1'b0;
                        if (!bus.I_fifo_full && seg_more) begin
                            state_q <= FE_ST_ARMED;
                            armed_q <= 1'b1;
                            count_q <= '0;
                        end else begin
                            state_q <= FE_ST_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= FE_ST_IDLE;
                    en_q    <= 1'b0;
                    armed_q <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.O_capture_enable = en_q;
    assign bus.O_armed          = armed_q;
    assign bus.O_done           = done_q;
    assign bus.O_overflow       = ovf_q;
    assign bus.O_count          = count_q;
    assign bus.O_state          = state_q;

endmodule

// File: tb/tb_fe_capture_ctrl.sv
// Bench for fe_capture_ctrl: vector table, directed sequences and
// randomized capture windows checked against a timeline model.
module tb_fe_capture_ctrl;

    logic fe_clk;
    logic reset_i;

    int n_cmp;
    int n_err;

    fe_capture_ctrl_if bus ();

    fe_capture_ctrl dut (
        .fe_clk  (fe_clk),
        .reset_i (reset_i),
        .bus     (bus)
    );

    initial fe_clk = 1'b0;
    always #5 fe_clk = ~fe_clk;

    typedef struct {
        logic arm;
        logic abort;
        logic trig;
        int   dly;
        int   len;
        logic wr;
        logic full;
        int   st;
        logic en;
        int   cnt;
        logic done;
        logic ovf;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(logic a, logic ab, logic t, int d, int l,
                                logic w, logic f, int st, logic en,
                                int cnt, logic dn, logic ov);
        vec_t v;
        v.arm = a; v.abort = ab; v.trig = t; v.dly = d; v.len = l;
        v.wr = w; v.full = f; v.st = st; v.en = en; v.cnt = cnt;
        v.done = dn; v.ovf = ov;
        return v;
    endfunction

    task automatic check(string nm, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step(logic a, logic ab, logic t, int d, int l,
                        logic w, logic f);
        bus.I_arm           = a;
        bus.I_abort         = ab;
        bus.I_trigger       = t;
        bus.I_trigger_delay = 20'(d);
        bus.I_capture_len   = 18'(l);
        bus.I_data_wr       = w;
        bus.I_fifo_full     = f;
        @(posedge fe_clk);
        #1;
    endtask

    task automatic expect_out(string tag, int st, logic en, int cnt,
                              logic dn, logic ov);
        check({tag, ".state"}, int'(bus.O_state), st);
        check({tag, ".enable"}, int'(bus.O_capture_enable), int'(en));
        check({tag, ".count"}, int'(bus.O_count), cnt);
        check({tag, ".done"}, int'(bus.O_done), int'(dn));
        check({tag, ".overflow"}, int'(bus.O_overflow), int'(ov));
        check({tag, ".armed"}, int'(bus.O_armed), (st == 1) ? 1 : 0);
    endtask

    // Timeline model: with the trigger at step T and delay D the window
    // opens after step T+D; writes at steps start+1..term are counted and
    // the window closes at the step where len is reached or full is seen.
    task automatic rand_scenario(int idx);
        bit wr[80];
        bit full[80];
        bit trg[80];
        bit arm[80];
        int len, d, g, t, start, last, term, n, cnt;
        int st;
        bit ended;
        string tag;
        tag   = $sformatf("rnd%0d", idx);
        len   = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 8);
        d     = $urandom_range(0, 10);
        g     = $urandom_range(0, 3);
        t     = g + 1;
        start = t + d;
        last  = start + 30;
        for (int k = 0; k <= last; k++) begin
            wr[k]   = ($urandom_range(0, 1) == 1);
            full[k] = ($urandom_range(0, 24) == 0);
            trg[k]  = 1'b0;
            arm[k]  = 1'b0;
        end
        term = -1;
        n    = 0;
        for (int k = start + 1; k <= last; k++) begin
            if (term < 0) begin
                if (wr[k]) n++;
                if (full[k] || (len != 0 && wr[k] && n == len)) term = k;
            end
        end
        trg[0] = ($urandom_range(0, 1) == 1);
        for (int k = 1; k < t; k++) arm[k] = ($urandom_range(0, 2) == 0);
        for (int k = t + 1; k <= last; k++) begin
            trg[k] = ($urandom_range(0, 3) == 0);
            if (term < 0 || k < term) arm[k] = ($urandom_range(0, 5) == 0);
        end
        cnt = 0;
        for (int k = 0; k <= last; k++) begin
            if (k == 0)
                step(1'b1, 1'b0, trg[0], $urandom_range(0, 9), len,
                     wr[0], full[0]);
            else
                step(arm[k], 1'b0, (k == t) || trg[k],
                     (k == t) ? d : $urandom_range(0, 9),
                     $urandom_range(0, 20), wr[k], full[k]);
            ended = (term >= 0) && (k >= term);
            if (k > start && (term < 0 || k <= term) && wr[k]) cnt++;
            if (k < t)          st = 1;
            else if (k < start) st = 2;
            else if (!ended)    st = 3;
            else                st = 4;
            expect_out($sformatf("%s.s%0d", tag, k), st,
                       (k >= start) && !ended, cnt, ended,
                       ended && full[term]);
        end
        if (term < 0) begin
            step(1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
            expect_out({tag, ".abort"}, 0, 1'b0, cnt, 1'b0, 1'b0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        reset_i = 1'b1;
`ifdef FE_CAPTURE_CTRL_SEGMENTS_EN
        bus.I_segments = 8'd0;
`endif
        step(1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 0, 3, 1'b1, 1'b1);
        expect_out("reset", 0, 1'b0, 0, 1'b0, 1'b0);
        reset_i = 1'b0;

        // arm+abort, trig-with-arm, stray arm, trigger in DELAY, drain
        vt.push_back(mk(1, 1, 0, 0, 4, 0, 0, 0, 0, 0, 0, 0));
        vt.push_back(mk(1, 0, 1, 3, 4, 0, 0, 1, 0, 0, 0, 0));
        vt.push_back(mk(1, 0, 0, 0, 9, 0, 0, 1, 0, 0, 0, 0));
        vt.push_back(mk(0, 0, 1, 5, 7, 0, 0, 2, 0, 0, 0, 0));
        vt.push_back(mk(0, 0, 1, 0, 0, 0, 0, 2, 0, 0, 0, 0));
        vt.push_back(mk(0, 0, 0, 1, 0, 1, 1, 2, 0, 0, 0, 0));
        vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0));
        vt.push_back(mk(1, 0, 0, 0, 1, 0, 0, 2, 0, 0, 0, 0));
        vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 3, 1, 0, 0, 0));
        vt.push_back(mk(0, 0, 0, 0, 1, 1, 0, 3, 1, 1, 0, 0));
        vt.push_back(mk(1, 0, 1, 0, 1, 1, 0, 3, 1, 2, 0, 0));
        vt.push_back(mk(0, 0, 0, 0, 1, 1, 0, 3, 1, 3, 0, 0));
        vt.push_back(mk(0, 0, 0, 0, 0, 1, 0, 4, 0, 4, 1, 0));
        vt.push_back(mk(0, 0, 0, 0, 0, 1, 0, 4, 0, 4, 1, 0));
        vt.push_back(mk(0, 0, 1, 0, 0, 0, 1, 4, 0, 4, 1, 0));
        vt.push_back(mk(1, 0, 0, 0, 2, 0, 0, 1, 0, 0, 0, 0));
        vt.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        foreach (vt[i]) begin
            step(vt[i].arm, vt[i].abort, vt[i].trig, vt[i].dly,
                 vt[i].len, vt[i].wr, vt[i].full);
            expect_out($sformatf("vec%0d", i), vt[i].st, vt[i].en,
                       vt[i].cnt, vt[i].done, vt[i].ovf);
        end

        // unlimited length, 1000 writes, then abort holds the count
        step(1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 0, 5, 1'b0, 1'b0);
        expect_out("unl.start", 3, 1'b1, 0, 1'b0, 1'b0);
        for (int i = 1; i <= 1000; i++) begin
            step(1'b0, 1'b0, 1'b0, 0, 0, 1'b1, 1'b0);
            check($sformatf("unl.en%0d", i),
                  int'(bus.O_capture_enable), 1);
        end
        step(1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
        expect_out("unl.abort", 0, 1'b0, 1000, 1'b0, 1'b0);

        // FIFO full after 7 writes, then re-arm clears status
        step(1'b1, 1'b0, 1'b0, 0, 16, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 0, 0, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 1'b0, 0, 0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b1);
        expect_out("ovf.done", 4, 1'b0, 7, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0, 0, 16, 1'b0, 1'b0);
        expect_out("ovf.rearm", 1, 1'b0, 0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0);

        // final write coincident with full still flags overflow
        step(1'b1, 1'b0, 1'b0, 0, 2, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 0, 0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 0, 0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 0, 0, 1'b1, 1'b1);
        expect_out("lastfull", 4, 1'b0, 2, 1'b1, 1'b1);

        // reset in the middle of a capture
        step(1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 0, 0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 0, 0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 0, 0, 1'b1, 1'b0);
        expect_out("midrst.pre", 3, 1'b1, 2, 1'b0, 1'b0);
        reset_i = 1'b1;
        step(1'b0, 1'b0, 1'b0, 0, 0, 1'b1, 1'b0);
        reset_i = 1'b0;
        expect_out("midrst", 0, 1'b0, 0, 1'b0, 1'b0);

`ifdef FE_CAPTURE_CTRL_SEGMENTS_EN
        bus.I_segments = 8'd3;
        step(1'b1, 1'b0, 1'b0, 0, 2, 1'b0, 1'b0);
        bus.I_segments = 8'd0;
        check("seg.arm", int'(bus.O_segment_count), 0);
        for (int w = 0; w < 3; w++) begin
            step(1'b0, 1'b0, 1'b1, 0, 0, 1'b0, 1'b0);
            expect_out($sformatf("seg%0d.cap", w), 3, 1'b1, 0, 1'b0, 1'b0);
            step(1'b0, 1'b0, 1'b0, 0, 0, 1'b1, 1'b0);
            step(1'b0, 1'b0, 1'b0, 0, 0, 1'b1, 1'b0);
            if (w < 2)
                expect_out($sformatf("seg%0d.end", w), 1, 1'b0, 0,
                           1'b0, 1'b0);
            else
                expect_out("seg2.end", 4, 1'b0, 2, 1'b1, 1'b0);
            check($sformatf("seg%0d.cnt", w), int'(bus.O_segment_count),
                  w + 1);
        end
`endif

        for (int s = 0; s < 40; s++) rand_scenario(s);

        step(1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
